// File: rtl/panel_input_conditioner.sv
// Front-panel input conditioner: 2-flop sync, 1 ms tick, per-input debounce, press/release pulses.
// Define PANEL_AUTOREPEAT_EN to compile in the shared auto-repeat FSM for buttons in REPEAT_MASK.
module panel_input_conditioner #(
  parameter int unsigned CLK_HZ          = 25000000,
  parameter int unsigned DEBOUNCE_MS     = 10,
  parameter int unsigned REPEAT_DELAY_MS = 500,
  parameter int unsigned REPEAT_RATE_MS  = 100,
  parameter logic [6:0]  REPEAT_MASK     = 7'b0101000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [6:0] btn_raw,
  input  logic [7:0] sense_raw,
  output logic [6:0] btn_level,
  output logic [6:0] btn_press,
  output logic [6:0] btn_release,
  output logic [7:0] sense_level,
  output logic       sense_changed,
  output logic       ms_tick
);

  localparam int unsigned TICKS = CLK_HZ / 1000;
  localparam int unsigned CW    = $clog2(TICKS + 1);
  localparam int unsigned N     = 15;
  // An out-of-range parameter set leaves the block inert instead of half-working.
  localparam bit CFG_OK = (TICKS >= 1) && (CLK_HZ % 1000 == 0) &&
                          (DEBOUNCE_MS >= 1) && (DEBOUNCE_MS <= 255) &&
                          (REPEAT_DELAY_MS >= 1) && (REPEAT_DELAY_MS <= 65535) &&
                          (REPEAT_RATE_MS >= 1) && (REPEAT_RATE_MS <= 65535) &&
                          (REPEAT_MASK != 7'h7f || REPEAT_MASK == 7'h7f);

  logic [N-1:0]  raw;
  logic [N-1:0]  meta_q, sync_q;
  logic [CW-1:0] pre_q, pre_d;
  logic          tick_q;
  logic [7:0]    dc_q [N];
  logic [7:0]    dc_d [N];
  logic [N-1:0]  lvl_q, lvl_d, lvl_prev_q;
  logic [6:0]    press_q, press_d, rel_q;
  logic          chg_q;
  logic [6:0]    rep;

  assign raw = {sense_raw, btn_raw};

  always_comb begin
    pre_d = (pre_q == CW'(TICKS - 1)) ? '0 : pre_q + CW'(1);
  end

  always_comb begin
    lvl_d = lvl_q;
    for (int i = 0; i < N; i++) begin
      dc_d[i] = dc_q[i];
      if (sync_q[i] == lvl_q[i]) begin
        dc_d[i] = '0;
      end else if (tick_q) begin
        if (dc_q[i] == 8'(DEBOUNCE_MS - 1)) begin
          lvl_d[i] = sync_q[i];
          dc_d[i]  = '0;
        end else begin
          dc_d[i] = dc_q[i] + 8'd1;
        end
      end
    end
  end

`ifdef PANEL_AUTOREPEAT_EN
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DELAY  = 2'd1;
  localparam logic [1:0] ST_REPEAT = 2'd2;

  logic [1:0]  st_q, st_d;
  logic [15:0] tmr_q, tmr_d;
  logic [6:0]  held, held_prev;

  assign held      = lvl_q[6:0] & REPEAT_MASK;
  assign held_prev = lvl_prev_q[6:0] & REPEAT_MASK;

  always_comb begin
    st_d  = st_q;
    tmr_d = tmr_q;
    rep   = '0;
    if (held == '0) begin
      st_d  = ST_IDLE;
      tmr_d = '0;
    end else if (held != held_prev) begin
      // Any change of the held set restarts the initial delay for all held buttons.
      st_d  = ST_DELAY;
      tmr_d = '0;
    end else begin
      case (st_q)
        ST_IDLE: begin
          st_d  = ST_DELAY;
          tmr_d = '0;
        end
        ST_DELAY: if (tick_q) begin
          if (tmr_q == 16'(REPEAT_DELAY_MS - 1)) begin
            rep   = held;
            tmr_d = '0;
            st_d  = ST_REPEAT;
          end else begin
            tmr_d = tmr_q + 16'd1;
          end
        end
        ST_REPEAT: if (tick_q) begin
          if (tmr_q == 16'(REPEAT_RATE_MS - 1)) begin
            rep   = held;
            tmr_d = '0;
          end else begin
            tmr_d = tmr_q + 16'd1;
          end
        end
        default: begin
          st_d  = ST_IDLE;
          tmr_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      st_q  <= ST_IDLE;
      tmr_q <= '0;
    end else begin
      st_q  <= st_d;
      tmr_q <= tmr_d;
    end
  end
`else
  assign rep = '0;
`endif

  assign press_d = (lvl_q[6:0] & ~lvl_prev_q[6:0]) | rep;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      meta_q     <= '0;
      sync_q     <= '0;
      pre_q      <= '0;
      tick_q     <= 1'b0;
      lvl_q      <= '0;
      lvl_prev_q <= '0;
      press_q    <= '0;
      rel_q      <= '0;
      chg_q      <= 1'b0;
      for (int i = 0; i < N; i++) dc_q[i] <= '0;
    end else begin
      meta_q     <= raw;
      sync_q     <= meta_q;
      pre_q      <= pre_d;
      tick_q     <= CFG_OK && (pre_d == CW'(TICKS - 1));
      lvl_q      <= lvl_d;
      lvl_prev_q <= lvl_q;
      press_q    <= press_d;
      rel_q      <= ~lvl_q[6:0] & lvl_prev_q[6:0];
      chg_q      <= |(lvl_q[14:7] ^ lvl_prev_q[14:7]);
      for (int i = 0; i < N; i++) dc_q[i] <= dc_d[i];
    end
  end

  assign btn_level     = lvl_q[6:0];
  assign sense_level   = lvl_q[14:7];
  assign btn_press     = press_q;
  assign btn_release   = rel_q;
  assign sense_changed = chg_q;
  assign ms_tick       = tick_q;

endmodule

// File: tb/tb_panel_input_conditioner.sv
// Scoreboard bench for panel_input_conditioner (tick every 10 cycles, 3 ms debounce, 5/2 ms repeat).
module tb_panel_input_conditioner;
  localparam int         CLK_HZ = 10000;
  localparam int         TPMS   = CLK_HZ / 1000;
  localparam int         DB     = 3;
  localparam int         RD     = 5;
  localparam int         RR     = 2;
  localparam logic [6:0] MASK   = 7'b0101000;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [6:0] btn_raw = '0;
  logic [7:0] sense_raw = '0;
  logic [6:0] btn_level, btn_press, btn_release;
  logic [7:0] sense_level;
  logic       sense_changed, ms_tick;

  panel_input_conditioner #(
    .CLK_HZ(CLK_HZ), .DEBOUNCE_MS(DB), .REPEAT_DELAY_MS(RD),
    .REPEAT_RATE_MS(RR), .REPEAT_MASK(MASK)
  ) dut (
    .clk(clk), .resetn(resetn), .btn_raw(btn_raw), .sense_raw(sense_raw),
    .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release),
    .sense_level(sense_level), .sense_changed(sense_changed), .ms_tick(ms_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [6:0] press;
    logic [6:0] rel;
    logic [6:0] lvl;
    logic       chg;
    logic [7:0] slvl;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model: raw seen two edges late, an input flips after DB consecutive
  // ticks of disagreement, repeats fall on the RD-th, RD+RR-th, ... tick after a held-set change.
  int          mcyc = 0;
  int          ecount;
  int          run [15];
  int          tcount;
  logic [14:0] r1, r2, lv, lv1;
  logic        exp_tick;

  always @(posedge clk or negedge resetn) begin : model
    logic        tick;
    logic [14:0] s, nl;
    logic [6:0]  rep, held, hp, press, rel;
    logic        chg;
    if (!resetn) begin
      ecount = 0; tcount = 0; r1 = '0; r2 = '0; lv = '0; lv1 = '0;
      exp_tick = 1'b0;
      for (int j = 0; j < 15; j++) run[j] = 0;
      q.delete();
    end else begin
      tick = (ecount % TPMS) == TPMS - 1;
      ecount++;
      mcyc++;
      s  = r2;
      nl = lv;
      for (int j = 0; j < 15; j++) begin
        if (s[j] == lv[j]) run[j] = 0;
        else if (tick) begin
          run[j]++;
          if (run[j] == DB) begin
            nl[j]  = s[j];
            run[j] = 0;
          end
        end
      end
      rep  = '0;
      held = lv[6:0] & MASK;
      hp   = lv1[6:0] & MASK;
`ifdef PANEL_AUTOREPEAT_EN
      if (held == '0 || held != hp) tcount = 0;
      else if (tick) begin
        tcount++;
        if (tcount >= RD && ((tcount - RD) % RR) == 0) rep = held;
      end
`endif
      press = (lv[6:0] & ~lv1[6:0]) | rep;
      rel   = ~lv[6:0] & lv1[6:0];
      chg   = |(lv[14:7] ^ lv1[14:7]);
      lv1 = lv;
      lv  = nl;
      r2  = r1;
      r1  = {sense_raw, btn_raw};
      exp_tick = (ecount % TPMS) == TPMS - 1;
      if (press != '0 || rel != '0 || chg)
        q.push_back('{mcyc, press, rel, lv[6:0], chg, lv[14:7]});
    end
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    if (resetn) begin
      while (q.size() != 0 && q[0].cyc < mcyc) begin
        e = q.pop_front();
        tests++; fails++;
        $display("FAIL missed_pulse cyc=%0d got none, need press=%b rel=%b chg=%b", e.cyc, e.press, e.rel, e.chg);
      end
      if (btn_press != '0 || btn_release != '0 || sense_changed) begin
        tests++;
        if (q.size() == 0 || q[0].cyc != mcyc) begin
          fails++;
          $display("FAIL unexpected_pulse cyc=%0d got press=%b rel=%b chg=%b, need none", mcyc, btn_press, btn_release, sense_changed);
        end else begin
          e = q.pop_front();
          if (btn_press !== e.press || btn_release !== e.rel || sense_changed !== e.chg ||
              btn_level !== e.lvl || sense_level !== e.slvl) begin
            fails++;
            $display("FAIL pulse cyc=%0d got p=%b r=%b c=%b bl=%b sl=%h, need p=%b r=%b c=%b bl=%b sl=%h",
                     mcyc, btn_press, btn_release, sense_changed, btn_level, sense_level,
                     e.press, e.rel, e.chg, e.lvl, e.slvl);
          end
        end
      end
      tests++;
      if (btn_level !== lv[6:0] || sense_level !== lv[14:7]) begin
        fails++;
        $display("FAIL levels cyc=%0d got bl=%b sl=%h, need bl=%b sl=%h", mcyc, btn_level, sense_level, lv[6:0], lv[14:7]);
      end
      tests++;
      if (ms_tick !== exp_tick) begin
        fails++;
        $display("FAIL ms_tick cyc=%0d got %b, need %b", mcyc, ms_tick, exp_tick);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_zero(input string name);
    tests++;
    if ({btn_level, btn_press, btn_release, sense_level, sense_changed, ms_tick} !== '0) begin
      fails++;
      $display("FAIL %s got bl=%b bp=%b br=%b sl=%h sc=%b tk=%b, need all 0", name,
               btn_level, btn_press, btn_release, sense_level, sense_changed, ms_tick);
    end
  endtask

  initial begin
    btn_raw[0] = 1'b1;
    cyc(4);
    check_zero("reset_state");
    resetn = 1'b1;
    cyc(50);
    btn_raw[0] = 1'b0;
    cyc(50);

    btn_raw[1] = 1'b1;
    cyc(40 + $urandom_range(0, 20));
    btn_raw[1] = 1'b0;
    cyc(50);

    repeat (7) begin
      btn_raw[2] = ~btn_raw[2];
      cyc(15);
    end
    btn_raw[2] = 1'b1;
    cyc(60);
    btn_raw[2] = 1'b0;
    cyc(50);

    sense_raw = 8'hA5;
    cyc(50);
    repeat (3) begin
      sense_raw = 8'($urandom);
      cyc(50);
    end

    btn_raw[3] = 1'b1; cyc(150); btn_raw[3] = 1'b0; cyc(50);
    btn_raw[1] = 1'b1; cyc(150); btn_raw[1] = 1'b0; cyc(50);

    btn_raw[3] = 1'b1; btn_raw[5] = 1'b1; cyc(120);
    btn_raw[3] = 1'b0; btn_raw[5] = 1'b0; cyc(50);
    btn_raw[3] = 1'b1; cyc(30);
    btn_raw[5] = 1'b1; cyc(120);
    btn_raw[3] = 1'b0; btn_raw[5] = 1'b0; cyc(50);

    repeat (40) begin
      btn_raw   = 7'($urandom);
      sense_raw = ($urandom_range(0, 1) == 1) ? 8'($urandom) : sense_raw;
      cyc($urandom_range(5, 80));
    end
    btn_raw = '0;
    cyc(60);

    btn_raw[3] = 1'b1;
    cyc(120 + $urandom_range(0, 15));
    sense_raw[0] = ~sense_raw[0];
    cyc(12);
    #2 resetn = 1'b0;
    #1 check_zero("reset_mid_op");
    cyc(3);
    resetn = 1'b1;
    cyc(100);
    btn_raw[3] = 1'b0;
    sense_raw  = '0;
    cyc(80);

    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL pending_pulses got %0d left, need 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
